// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, behind valid/ready handshakes.
module mips_alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             is_zero,
   output logic             div_zero,
   output logic             busy
);

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_XOR   = 4'd3;
   localparam logic [3:0] OP_SLL   = 4'd4;
   localparam logic [3:0] OP_SRL   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_SLTU  = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_MULT  = 4'd10;
   localparam logic [3:0] OP_MULTU = 4'd11;
   localparam logic [3:0] OP_NOR   = 4'd12;
   localparam logic [3:0] OP_DIV   = 4'd13;
   localparam logic [3:0] OP_DIVU  = 4'd14;

   localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];
   localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic [SHW:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic                 neg_lo_q, neg_lo_d;
   logic                 neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic                 is_zero_q, is_zero_d;
   logic                 div_zero_q, div_zero_d;

   logic [SHW-1:0]       sh;
   logic [WIDTH-1:0]     single_res;
   logic                 is_mul_in, is_div_in, long_signed;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic                 op_is_mul_q;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_sub;
   logic [WIDTH-1:0]     step_hi, step_lo;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;

   assign sh = b[SHW-1:0];

   always_comb begin
      single_res = '0;
      case (op)
         OP_AND:  single_res = a & b;
         OP_OR:   single_res = a | b;
         OP_ADD:  single_res = a + b;
         OP_XOR:  single_res = a ^ b;
         OP_SLL:  single_res = a << sh;
         OP_SRL:  single_res = a >> sh;
         OP_SUB:  single_res = a - b;
         OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SRA:  single_res = $unsigned($signed(a) >>> sh);
         OP_NOR:  single_res = ~(a | b);
         default: single_res = '0;
      endcase
   end

   // Long ops run on magnitudes; the sign flags captured at accept drive the final fix-up.
   assign is_mul_in   = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div_in   = (op == OP_DIV)  || (op == OP_DIVU);
   assign long_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg       = long_signed & a[WIDTH-1];
   assign b_neg       = long_signed & b[WIDTH-1];
   assign a_mag       = a_neg ? -a : a;
   assign b_mag       = b_neg ? -b : b;
   assign op_is_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);

   // Multiply: {acc_hi, acc_lo} shifts right, adding the multiplicand into the top half.
   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
   assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, mcand_q & {WIDTH{acc_lo_q[0]}}};
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, mcand_q});
   assign div_sub   = div_shift[WIDTH-1:0] - mcand_q;

   always_comb begin
      if (op_is_mul_q) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end else begin
         step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
      end
   end

   assign prod_fix = neg_lo_q ? -{step_hi, step_lo} : {step_hi, step_lo};
   assign quot_fix = neg_lo_q ? -step_lo : step_lo;
   assign rem_fix  = neg_hi_q ? -step_hi : step_hi;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      mcand_d    = mcand_q;
      a_d        = a_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      result_d   = result_q;
      hi_d       = hi_q;
      is_zero_d  = is_zero_q;
      div_zero_d = div_zero_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d = op;
               a_d  = a;
               if (is_mul_in || is_div_in) begin
                  state_d  = S_BUSY;
                  cnt_d    = CNT_INIT;
                  acc_hi_d = '0;
                  acc_lo_d = is_mul_in ? b_mag : a_mag;
                  mcand_d  = is_mul_in ? a_mag : b_mag;
                  neg_lo_d = a_neg ^ b_neg;
                  // Remainder follows the dividend's sign; product follows the sign product.
                  neg_hi_d = is_mul_in ? (a_neg ^ b_neg) : a_neg;
               end else begin
                  state_d    = S_DONE;
                  result_d   = single_res;
                  hi_d       = '0;
                  is_zero_d  = (single_res == '0);
                  div_zero_d = 1'b0;
               end
            end
         end
         S_BUSY: begin
            cnt_d    = cnt_q - CNT_ONE;
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            if (cnt_q == CNT_ONE) begin
               state_d    = S_DONE;
               div_zero_d = 1'b0;
               if (op_is_mul_q) begin
                  result_d = prod_fix[WIDTH-1:0];
                  hi_d     = prod_fix[2*WIDTH-1:WIDTH];
               end else if (mcand_q == '0) begin
                  result_d   = '1;
                  hi_d       = a_q;
                  div_zero_d = 1'b1;
               end else begin
                  result_d = quot_fix;
                  hi_d     = rem_fix;
               end
               is_zero_d = (result_d == '0);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         mcand_q    <= '0;
         a_q        <= '0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         result_q   <= '0;
         hi_q       <= '0;
         is_zero_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         mcand_q    <= mcand_d;
         a_q        <= a_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         result_q   <= result_d;
         hi_q       <= hi_d;
         is_zero_q  <= is_zero_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_BUSY);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign hi        = hi_q;
   assign is_zero   = is_zero_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_mips_alu_mc.sv
// Scoreboard bench for mips_alu_mc: expected results come from a behavioural model
// using native SystemVerilog arithmetic, queued at issue and popped at result.
module tb_mips_alu_mc;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic [W-1:0]  hi;
   logic          is_zero;
   logic          div_zero;
   logic          busy;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   mips_alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .hi(hi), .is_zero(is_zero), .div_zero(div_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t           e;
      logic [4:0]     s;
      longint         sx, sy, q, r;
      logic [63:0]    p;
      e.res = '0; e.hi = '0; e.dz = 1'b0; e.lat = 0;
      s  = y[4:0];
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         4'd0:  e.res = x & y;
         4'd1:  e.res = x | y;
         4'd2:  e.res = x + y;
         4'd3:  e.res = x ^ y;
         4'd4:  e.res = x << s;
         4'd5:  e.res = x >> s;
         4'd6:  e.res = x - y;
         4'd7:  e.res = {31'b0, x < y};
         4'd8:  e.res = {31'b0, $signed(x) < $signed(y)};
         4'd9:  e.res = $unsigned($signed(x) >>> s);
         4'd10: begin p = sx * sy; e.res = p[31:0]; e.hi = p[63:32]; e.lat = W; end
         4'd11: begin p = {32'b0, x} * {32'b0, y}; e.res = p[31:0]; e.hi = p[63:32]; e.lat = W; end
         4'd12: e.res = ~(x | y);
         4'd13, 4'd14: begin
            e.lat = W;
            if (y == 0) begin
               e.res = '1; e.hi = x; e.dz = 1'b1;
            end else if (o == 4'd13) begin
               q = sx / sy; r = sx % sy;
               e.res = q[31:0]; e.hi = r[31:0];
            end else begin
               e.res = x / y; e.hi = x % y;
            end
         end
         default: e.res = '0;
      endcase
      e.z = (e.res == 0);
      return e;
   endfunction

   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      sb_q.push_back(model(o, x, y));
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      #1;
      checks++;
      if ({out_valid, in_ready, busy, result, hi, is_zero, div_zero} !== {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got ov=%b ir=%b busy=%b res=%h hi=%h z=%b dz=%b required ov=0 ir=1 busy=0 res=0 hi=0 z=0 dz=0",
                  out_valid, in_ready, busy, result, hi, is_zero, div_zero);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      exp_t e; int lat;
      out_ready = 1'b1;
      issue(4'd2, 32'd5, 32'd7);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== e.lat) begin failures++; $display("FAIL add_latency got=%0d required=%0d", lat, e.lat); end
      checks++;
      if ({result, hi, is_zero, div_zero} !== {e.res, e.hi, e.z, e.dz}) begin
         failures++; $display("FAIL add_value got res=%h z=%b required res=%h z=%b", result, is_zero, e.res, e.z);
      end
      $display("txn add res=%h hi=%h lat=%0d", result, hi, lat);
      handoff();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++; $display("FAIL add_ready_after got ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   task automatic test_compare();
      logic [3:0]   ops [3] = '{4'd8, 4'd7, 4'd6};
      logic [W-1:0] xs  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9};
      logic [W-1:0] ys  [3] = '{32'd1, 32'd1, 32'd9};
      exp_t e; int lat;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], xs[i], ys[i]);
         wait_valid(lat);
         e = sb_q.pop_front();
         checks++;
         if ({lat, result, hi, is_zero, div_zero} !== {e.lat, e.res, e.hi, e.z, e.dz}) begin
            failures++;
            $display("FAIL cmp_op%0d got lat=%0d res=%h z=%b required lat=%0d res=%h z=%b", ops[i], lat, result, is_zero, e.lat, e.res, e.z);
         end
         $display("txn cmp op=%0d res=%h z=%b lat=%0d", ops[i], result, is_zero, lat);
         handoff();
      end
   endtask

   task automatic test_mult();
      exp_t e; int lat; int bad;
      issue(4'd10, 32'hFFFF_FFFD, 32'd5);
      lat = 0; bad = 0;
      while (!out_valid && lat < 200) begin
         if (!(busy === 1'b1 && in_ready === 1'b0)) bad++;
         @(posedge clk); #1;
         lat++;
      end
      e = sb_q.pop_front();
      checks++;
      if (bad != 0) begin failures++; $display("FAIL mult_busy got %0d cycles not busy required 0", bad); end
      checks++;
      if (lat !== e.lat) begin failures++; $display("FAIL mult_latency got=%0d required=%0d", lat, e.lat); end
      checks++;
      if ({result, hi, is_zero, div_zero} !== {e.res, e.hi, e.z, e.dz}) begin
         failures++; $display("FAIL mult_value got hi=%h res=%h required hi=%h res=%h", hi, result, e.hi, e.res);
      end
      $display("txn mult res=%h hi=%h lat=%0d", result, hi, lat);
      handoff();
   endtask

   task automatic test_div();
      logic [3:0]   ops [3] = '{4'd13, 4'd14, 4'd13};
      logic [W-1:0] xs  [3] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
      logic [W-1:0] ys  [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
      exp_t e; int lat;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], xs[i], ys[i]);
         wait_valid(lat);
         e = sb_q.pop_front();
         checks++;
         if ({lat, result, hi, is_zero, div_zero} !== {e.lat, e.res, e.hi, e.z, e.dz}) begin
            failures++;
            $display("FAIL div_case%0d got lat=%0d res=%h hi=%h dz=%b required lat=%0d res=%h hi=%h dz=%b",
                     i, lat, result, hi, div_zero, e.lat, e.res, e.hi, e.dz);
         end
         $display("txn div op=%0d res=%h hi=%h dz=%b lat=%0d", ops[i], result, hi, div_zero, lat);
         handoff();
      end
   endtask

   task automatic test_backpressure();
      exp_t e; int lat;
      issue(4'd9, 32'h8000_0000, 32'd4);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if ({lat, result, is_zero} !== {e.lat, e.res, e.z}) begin
         failures++; $display("FAIL bp_value got lat=%0d res=%h required lat=%0d res=%h", lat, result, e.lat, e.res);
      end
      $display("txn sra res=%h hi=%h lat=%0d", result, hi, lat);
      op = 4'd2; a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         a = a + 32'd3;
         checks++;
         if ({out_valid, in_ready, busy, result, hi, is_zero, div_zero} !== {1'b1, 1'b0, 1'b0, e.res, e.hi, e.z, e.dz}) begin
            failures++;
            $display("FAIL bp_hold%0d got ov=%b ir=%b res=%h hi=%h required ov=1 ir=0 res=%h hi=%h", i, out_valid, in_ready, result, hi, e.res, e.hi);
         end
      end
      handoff();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         failures++; $display("FAIL bp_release got ir=%b ov=%b busy=%b required ir=1 ov=0 busy=0", in_ready, out_valid, busy);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         failures++; $display("FAIL bp_no_accept got ir=%b ov=%b busy=%b required ir=1 ov=0 busy=0", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e; int lat;
      issue(4'd11, 32'h1234_5678, 32'd9);
      repeat (9) begin @(posedge clk); #1; end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b required=1", busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, busy, result, hi, is_zero, div_zero} !== {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rst_mid_state got ov=%b ir=%b busy=%b res=%h hi=%h z=%b dz=%b required ov=0 ir=1 busy=0 res=0 hi=0 z=0 dz=0",
                  out_valid, in_ready, busy, result, hi, is_zero, div_zero);
      end
      sb_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(4'd2, 32'd1, 32'd1);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if ({lat, result, hi, is_zero} !== {e.lat, e.res, e.hi, e.z}) begin
         failures++; $display("FAIL rst_mid_add got lat=%0d res=%h required lat=%0d res=%h", lat, result, e.lat, e.res);
      end
      $display("txn add_after_reset res=%h lat=%0d", result, lat);
      handoff();
   endtask

   task automatic test_back_to_back();
      exp_t e; int lat;
      logic [3:0] o; logic [W-1:0] x, y;
      for (int i = 0; i < 40; i++) begin
         o = 4'($urandom_range(0, 15));
         x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0:       y = 32'd0;
            1:       y = $urandom_range(0, 40);
            2:       y = 32'hFFFF_FFFF;
            default: y = $urandom;
         endcase
         issue(o, x, y);
         wait_valid(lat);
         e = sb_q.pop_front();
         checks++;
         if ({lat, result, hi, is_zero, div_zero} !== {e.lat, e.res, e.hi, e.z, e.dz}) begin
            failures++;
            $display("FAIL b2b_%0d op=%0d a=%h b=%h got lat=%0d res=%h hi=%h z=%b dz=%b required lat=%0d res=%h hi=%h z=%b dz=%b",
                     i, o, x, y, lat, result, hi, is_zero, div_zero, e.lat, e.res, e.hi, e.z, e.dz);
         end
         $display("txn b2b op=%0d a=%h b=%h res=%h hi=%h lat=%0d", o, x, y, result, hi, lat);
         handoff();
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_compare();
      test_mult();
      test_div();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
